free_ptr_manager: RTL and testbench
===================================

# free_ptr_manager

Parametrised free-pointer manager for the switch's shared packet buffer. After reset it self-initialises a pool of DEPTH buffer-page pointers (BASE..BASE+DEPTH-1). It then serves allocation requests from the ingress writer and accepts returned pointers from the egress reader. It replaces the fixed 10-bit/512-entry free-queue, adding a configurable base, occupancy reporting, error flags and optional range checking of returned pointers.

## Interface
- ADDR_W, 10, pointer width in bits.
- DEPTH, 512, number of pointers in the pool; 2 ≤ DEPTH ≤ 2^ADDR_W.
- BASE, 0, first pointer value; BASE+DEPTH-1 < 2^ADDR_W.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- init_done  out  1  high once the pool is fully loaded; stays high until next reset.
- alloc_valid  out  1  a free pointer is presented on alloc_ptr.
- alloc_ptr  out  ADDR_W  head-of-queue pointer (first-word-fall-through).
- alloc_rd  in  1  pop alloc_ptr; honoured only when alloc_valid=1.
- free_wr  in  1  return free_ptr to the pool.
- free_ptr  in  ADDR_W  pointer being returned.
- free_cnt  out  ADDR_W+1  number of pointers currently in the pool.
- ovf_err  out  1  one-cycle pulse: free_wr dropped because pool full.
- udf_err  out  1  one-cycle pulse: alloc_rd while alloc_valid=0 (after init).
- ptr_err  out  1  one-cycle pulse: free_ptr out of range (see Configuration).

## Operation
- Storage: DEPTH×ADDR_W register array, read index rd_idx and write index wr_idx. Each index wraps from DEPTH-1 to 0; DEPTH need not be a power of two. Occupancy is held in free_cnt.
- FSM states:
  - INIT: entered on reset. Each cycle writes BASE+k at index k, k=0..DEPTH-1. After writing k=DEPTH-1, moves to RUN with free_cnt=DEPTH and wr_idx=0.
  - RUN: normal service; remains in RUN until reset.
- During INIT:
  - alloc_valid=0.
  - alloc_rd and free_wr are ignored; no error flags are raised.
- In RUN, alloc:
  - alloc_valid = (free_cnt≠0).
  - alloc_rd with alloc_valid=1 advances rd_idx and decrements free_cnt.
  - alloc_rd with alloc_valid=0 has no effect except pulsing udf_err.
- In RUN, free:
  - free_wr with free_cnt<DEPTH (or with a simultaneous accepted alloc) writes free_ptr at wr_idx, advances wr_idx and increments free_cnt.
  - free_wr with free_cnt=DEPTH and no accepted alloc drops the write and pulses ovf_err.
- Simultaneous accepted alloc and free: both execute and free_cnt is unchanged.
- Empty pool: there is no free-to-alloc bypass. A pointer freed while empty becomes visible on alloc_ptr the following cycle.
- Reset asserted mid-operation: all state is lost and the FSM returns to INIT. Pointers outstanding downstream are considered reclaimed.

## Timing
- Reset values: init_done=0, alloc_valid=0, alloc_ptr=0, free_cnt=0, ovf_err=0, udf_err=0, ptr_err=0.
- INIT duration:
  - The first rising edge with rst=1 writes pointer BASE.
  - The edge numbered DEPTH-1 writes the last pointer.
  - From that edge: init_done=1, alloc_valid=1, alloc_ptr=BASE, free_cnt=DEPTH.
- alloc_ptr is registered and valid in the same cycle as alloc_valid. After a pop, the next pointer appears on the following cycle.
- Free-to-visible latency: 1 cycle when the pool was empty.
- free_cnt updates one cycle after the accepted request.
- Error pulses are registered and assert one cycle after the offending request, for exactly one cycle.

## Configuration
- FREE_PTR_CHECK_EN defined:
  - In RUN, a free_wr with free_ptr<BASE or free_ptr>BASE+DEPTH-1 is dropped and pulses ptr_err.
  - An out-of-range free that would also overflow pulses ptr_err only.
- FREE_PTR_CHECK_EN undefined: no range check; ptr_err is tied 0; any free_ptr value is stored.

## Test plan
- Reset release, DEPTH=8, BASE=4: init_done rises on the 8th edge; eight pops return 4,5,…,11 in order; then alloc_valid=0 and free_cnt=0.
- After draining, free 9 then 5: alloc_valid rises one cycle after the first free; pops return 9, then 5.
- Full pool (free_cnt=8): free_wr of 6 → ovf_err pulses once and free_cnt stays 8. The same cycle with alloc_rd=1 → both accepted and free_cnt stays 8.
- Empty pool: alloc_rd=1 → udf_err pulses once and alloc_ptr/free_cnt are unchanged. alloc_rd during INIT → no udf_err.
- With FREE_PTR_CHECK_EN, BASE=4: free_ptr=3 or 12 → ptr_err pulses and the pointer is not stored. Without the macro, 12 is stored and returned on the next pop from an empty pool.
- Reset asserted after 3 pops: outputs return to reset values; after re-init, pops restart at BASE.

Source files
------------

// File: rtl/free_ptr_manager.sv
// rtl/free_ptr_manager.sv - self-initialising free-pointer pool for the shared packet buffer
// Optional build macro: FREE_PTR_CHECK_EN (drop and flag returned pointers outside BASE..BASE+DEPTH-1)
module free_ptr_manager #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 512,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_done,
  output logic              alloc_valid,
  output logic [ADDR_W-1:0] alloc_ptr,
  input  logic              alloc_rd,
  input  logic              free_wr,
  input  logic [ADDR_W-1:0] free_ptr,
  output logic [ADDR_W:0]   free_cnt,
  output logic              ovf_err,
  output logic              udf_err,
  output logic              ptr_err
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_BASE = ADDR_W'(BASE);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] alloc_ptr_q, alloc_ptr_d;
  logic              alloc_valid_q, alloc_valid_d;
  logic              init_done_q, init_done_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              ptr_err_q, ptr_err_d;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [ADDR_W-1:0] mem_wdata;

  logic              pop;
  logic              push;
  logic              range_ok;
  logic [IDX_W-1:0]  rd_next;

  // Indices wrap at DEPTH-1 so non-power-of-two pools work.
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_LAST) ? '0 : idx + 1'b1;
  endfunction

`ifdef FREE_PTR_CHECK_EN
  localparam logic [ADDR_W:0] PTR_LO = (ADDR_W + 1)'(BASE);
  localparam logic [ADDR_W:0] PTR_HI = (ADDR_W + 1)'(BASE + DEPTH - 1);
  assign range_ok = ({1'b0, free_ptr} >= PTR_LO) && ({1'b0, free_ptr} <= PTR_HI);
`else
  // Without the check every returned value is stored, so ptr_err never fires.
  assign range_ok = 1'b1;
`endif

  // Next-state logic: pool loading in INIT, alloc/free service in RUN.
  always_comb begin
    state_d       = state_q;
    rd_idx_d      = rd_idx_q;
    wr_idx_d      = wr_idx_q;
    cnt_d         = cnt_q;
    alloc_ptr_d   = alloc_ptr_q;
    alloc_valid_d = alloc_valid_q;
    init_done_d   = init_done_q;
    ovf_d         = 1'b0;
    udf_d         = 1'b0;
    ptr_err_d     = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = wr_idx_q;
    mem_wdata     = free_ptr;
    pop           = 1'b0;
    push          = 1'b0;
    rd_next       = rd_idx_q;

    if (state_q == ST_INIT) begin
      // wr_idx doubles as the load counter; requests are ignored here.
      mem_we    = 1'b1;
      mem_wdata = PTR_BASE + ADDR_W'(wr_idx_q);
      wr_idx_d  = idx_inc(wr_idx_q);
      if (wr_idx_q == IDX_LAST) begin
        state_d       = ST_RUN;
        wr_idx_d      = '0;
        rd_idx_d      = '0;
        cnt_d         = CNT_FULL;
        alloc_valid_d = 1'b1;
        alloc_ptr_d   = PTR_BASE;
        init_done_d   = 1'b1;
      end
    end else begin
      pop   = alloc_rd && alloc_valid_q;
      udf_d = alloc_rd && !alloc_valid_q;

      // A range error takes priority over overflow, and a full pool still
      // accepts a free when the same cycle's pop makes room.
      if (free_wr) begin
        if (!range_ok) begin
          ptr_err_d = 1'b1;
        end else if ((cnt_q != CNT_FULL) || pop) begin
          push = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end

      rd_next  = pop ? idx_inc(rd_idx_q) : rd_idx_q;
      rd_idx_d = rd_next;

      if (push) begin
        mem_we   = 1'b1;
        wr_idx_d = idx_inc(wr_idx_q);
      end

      if (push && !pop) begin
        cnt_d = cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_d = cnt_q - 1'b1;
      end

      alloc_valid_d = (cnt_d != '0);

      // The head register is refreshed only while the pool holds something,
      // so alloc_ptr stays put when empty. A pointer written into the slot
      // that becomes the head is forwarded because the array write lands
      // at the same edge.
      if (cnt_d != '0) begin
        alloc_ptr_d = (push && (wr_idx_q == rd_next)) ? free_ptr : mem_q[rd_next];
      end
    end
  end

  // Control state, head pointer and registered status/error outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_INIT;
      rd_idx_q      <= '0;
      wr_idx_q      <= '0;
      cnt_q         <= '0;
      alloc_ptr_q   <= '0;
      alloc_valid_q <= 1'b0;
      init_done_q   <= 1'b0;
      ovf_q         <= 1'b0;
      udf_q         <= 1'b0;
      ptr_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_idx_q      <= rd_idx_d;
      wr_idx_q      <= wr_idx_d;
      cnt_q         <= cnt_d;
      alloc_ptr_q   <= alloc_ptr_d;
      alloc_valid_q <= alloc_valid_d;
      init_done_q   <= init_done_d;
      ovf_q         <= ovf_d;
      udf_q         <= udf_d;
      ptr_err_q     <= ptr_err_d;
    end
  end

  // Pointer storage; contents are rebuilt by INIT after every reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign init_done   = init_done_q;
  assign alloc_valid = alloc_valid_q;
  assign alloc_ptr   = alloc_ptr_q;
  assign free_cnt    = cnt_q;
  assign ovf_err     = ovf_q;
  assign udf_err     = udf_q;
  assign ptr_err     = ptr_err_q;

endmodule

// File: tb/tb_free_ptr_manager.sv
// tb/tb_free_ptr_manager.sv - randomized and directed bench for free_ptr_manager against a queue model
module tb_free_ptr_manager;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 8;
  localparam int BASE   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              init_done;
  logic              alloc_valid;
  logic [ADDR_W-1:0] alloc_ptr;
  logic              alloc_rd;
  logic              free_wr;
  logic [ADDR_W-1:0] free_ptr;
  logic [ADDR_W:0]   free_cnt;
  logic              ovf_err;
  logic              udf_err;
  logic              ptr_err;

  free_ptr_manager #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH),
    .BASE  (BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .init_done  (init_done),
    .alloc_valid(alloc_valid),
    .alloc_ptr  (alloc_ptr),
    .alloc_rd   (alloc_rd),
    .free_wr    (free_wr),
    .free_ptr   (free_ptr),
    .free_cnt   (free_cnt),
    .ovf_err    (ovf_err),
    .udf_err    (udf_err),
    .ptr_err    (ptr_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the pool is a plain FIFO of pointer values.
  int q[$];
  int head;
  bit ready;
  int init_edges;
  bit e_ovf, e_udf, e_ptr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_range(input int p);
`ifdef FREE_PTR_CHECK_EN
    return (p >= BASE) && (p <= BASE + DEPTH - 1);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    head       = 0;
    ready      = 0;
    init_edges = 0;
    e_ovf      = 0;
    e_udf      = 0;
    e_ptr      = 0;
  endtask

  task automatic model_edge(input bit a, input bit f, input int p);
    bit did_pop;
    bit was_full;
    e_ovf = 0;
    e_udf = 0;
    e_ptr = 0;
    if (!ready) begin
      init_edges++;
      if (init_edges == DEPTH) begin
        for (int k = 0; k < DEPTH; k++) q.push_back(BASE + k);
        ready = 1;
      end
    end else begin
      did_pop  = a && (q.size() > 0);
      e_udf    = a && (q.size() == 0);
      was_full = (q.size() == DEPTH);
      if (did_pop) void'(q.pop_front());
      if (f) begin
        if (!in_range(p)) e_ptr = 1;
        else if (!was_full || did_pop) q.push_back(p);
        else e_ovf = 1;
      end
    end
    if (q.size() > 0) head = q[0];
  endtask

  task automatic check_outputs();
    check("init_done",   init_done,   ready);
    check("alloc_valid", alloc_valid, ready && (q.size() > 0));
    check("alloc_ptr",   alloc_ptr,   head);
    check("free_cnt",    free_cnt,    q.size());
    check("ovf_err",     ovf_err,     e_ovf);
    check("udf_err",     udf_err,     e_udf);
    check("ptr_err",     ptr_err,     e_ptr);
  endtask

  // Drive one cycle of requests at the falling edge, update the model at
  // the rising edge, and compare at the next falling edge.
  task automatic cycle(input bit a, input bit f, input int p);
    alloc_rd = a;
    free_wr  = f;
    free_ptr = ADDR_W'(p);
    @(posedge clk);
    if (rst) model_edge(a, f, p);
    @(negedge clk);
    alloc_rd = 1'b0;
    free_wr  = 1'b0;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst      = 1'b0;
    alloc_rd = 1'b0;
    free_wr  = 1'b0;
    free_ptr = '0;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;

    // INIT with requests applied: they must be ignored and raise no errors.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, 5);
    cycle(1'b0, 1'b0, 0);

    // Drain the pool, then underflow once.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b0, 0);

    // Return 9 then 5 to an empty pool and pop them back.
    cycle(1'b0, 1'b1, 9);
    cycle(1'b0, 1'b1, 5);
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b0, 0);

    // Fill to full, overflow, then simultaneous alloc and free at full.
    for (int k = 0; k < DEPTH; k++) cycle(1'b0, 1'b1, BASE + k);
    cycle(1'b0, 1'b1, 6);
    cycle(1'b1, 1'b1, 6);
    cycle(1'b0, 1'b1, 15);
    cycle(1'b0, 1'b0, 0);

    // Drain, then out-of-range returns into an empty pool.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b1, 3);
    cycle(1'b0, 1'b1, 12);
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b0, 0);

    // Random traffic across the whole pointer space.
    for (int i = 0; i < 600; i++) begin
      cycle(1'(($urandom_range(0, 99) < 45) ? 1 : 0),
            1'(($urandom_range(0, 99) < 50) ? 1 : 0),
            int'($urandom_range(0, 15)));
    end

    // Reset after three pops: outputs clear and pops restart at BASE.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0);
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
